// File: rtl/icache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_assoc_pkg;

   typedef enum logic {StIdle, StFill} icache_assoc_state_t;

   // Field width that stays at least 1 bit when the range has a single entry.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned plru_width(input int unsigned ways);
      return (ways == 4) ? 3 : 1;
   endfunction

endpackage

// File: rtl/icache_assoc_plru_set.sv
// Replacement state for one cache set: victim choice and update after an access.
module icache_assoc_plru_set
   import icache_assoc_pkg::*;
#(
   parameter int unsigned WAYS = 2,
   localparam int unsigned WayW = safe_clog2(WAYS),
   localparam int unsigned LruW = plru_width(WAYS)
) (
   input  logic [LruW-1:0] lru_i,
   input  logic [WayW-1:0] way_i,
   output logic [WayW-1:0] victim_o,
   output logic [LruW-1:0] lru_o
);

   if (WAYS == 4) begin : g_tree
      // Bit 0 selects the half holding the victim; bits 1/2 select within each pair.
      assign victim_o = lru_i[0] ? {1'b1, lru_i[2]} : {1'b0, lru_i[1]};
      always_comb begin
         lru_o    = lru_i;
         lru_o[0] = ~way_i[1];
         if (way_i[1]) begin
            lru_o[2] = ~way_i[0];
         end else begin
            lru_o[1] = ~way_i[0];
         end
      end
   end else if (WAYS == 2) begin : g_pair
      assign victim_o = lru_i;
      assign lru_o    = ~way_i;
   end else begin : g_direct
      logic unused_way;
      assign unused_way = ^way_i;
      assign victim_o   = '0;
      assign lru_o      = lru_i;
   end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with LRU replacement, multi-word
// block fill, single-cycle invalidate and hit/miss counters.
module icache_assoc
   import icache_assoc_pkg::*;
#(
   parameter int unsigned CPUID = 0,
   parameter int unsigned SETS  = 8,
   parameter int unsigned WAYS  = 2,
   parameter int unsigned WORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        iinval,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int unsigned IdxW    = $clog2(SETS);
   localparam int unsigned WofBits = $clog2(WORDS);
   localparam int unsigned WofW    = safe_clog2(WORDS);
   localparam int unsigned TagW    = 32 - 2 - WofBits - IdxW;
   localparam int unsigned WayW    = safe_clog2(WAYS);
   localparam int unsigned LruW    = plru_width(WAYS);

   typedef struct packed {
      logic [TagW-1:0] tag;
      logic [IdxW-1:0] idx;
      logic [WofW-1:0] wof;
      logic [1:0]      bof;
   } icache_addr_t;

   icache_assoc_state_t          state_q;
   logic [TagW-1:0]              tag_q;
   logic [IdxW-1:0]              idx_q;
   logic [WofW-1:0]              cnt_q;
   logic [WayW-1:0]              victim_q;
   logic [SETS-1:0][WAYS-1:0]    valid_q;
   logic [SETS-1:0][LruW-1:0]    lru_q;
   logic [31:0]                  hit_count_q;
   logic [31:0]                  miss_count_q;
   logic [TagW-1:0]              tags_q [SETS][WAYS];
   logic [31:0]                  data_q [SETS][WAYS][WORDS];

   icache_addr_t    req;
   logic [WAYS-1:0] match;
   logic [WayW-1:0] hit_way;
   logic [WayW-1:0] inv_way;
   logic            inv_found;
   logic [WayW-1:0] plru_victim;
   logic [WayW-1:0] victim;
   logic [LruW-1:0] lru_hit_upd;
   logic [LruW-1:0] lru_fill_upd;
   logic [WayW-1:0] unused_fill_victim;
   logic            unused_bof;
   logic            lookup;
   logic            miss;
   logic            fill_beat;
   logic            last_beat;
   logic [31:0]     fill_addr;

   // With WORDS=1 the offset field is a constant 0 and bit 2 belongs to the index.
   always_comb begin
      req.tag = imemaddr[31 -: TagW];
      req.idx = imemaddr[2+WofBits +: IdxW];
      req.wof = '0;
      if (WORDS > 1) begin
         req.wof = imemaddr[2 +: WofW];
      end
      req.bof = imemaddr[1:0];
   end
   assign unused_bof = ^req.bof;

   always_comb begin
      match     = '0;
      hit_way   = '0;
      inv_way   = '0;
      inv_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = valid_q[req.idx][w] && (tags_q[req.idx][w] == req.tag);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            hit_way = WayW'(w);
         end
         if (!valid_q[req.idx][w]) begin
            inv_way   = WayW'(w);
            inv_found = 1'b1;
         end
      end
   end

   icache_assoc_plru_set #(
      .WAYS(WAYS)
   ) u_plru_req (
      .lru_i   (lru_q[req.idx]),
      .way_i   (hit_way),
      .victim_o(plru_victim),
      .lru_o   (lru_hit_upd)
   );

   icache_assoc_plru_set #(
      .WAYS(WAYS)
   ) u_plru_fill (
      .lru_i   (lru_q[idx_q]),
      .way_i   (victim_q),
      .victim_o(unused_fill_victim),
      .lru_o   (lru_fill_upd)
   );

   assign victim    = inv_found ? inv_way : plru_victim;
   assign lookup    = (state_q == StIdle) && imemREN && !iinval;
   assign ihit      = lookup && (|match);
   assign miss      = lookup && !(|match);
   assign imemload  = ihit ? data_q[req.idx][hit_way][req.wof] : '0;
   assign fill_beat = (state_q == StFill) && !iwait && !iinval;
   assign last_beat = fill_beat && (cnt_q == WofW'(WORDS - 1));

   always_comb begin
      fill_addr                      = '0;
      fill_addr[2 +: WofW]           = cnt_q;
      fill_addr[2+WofBits +: IdxW]   = idx_q;
      fill_addr[31 -: TagW]          = tag_q;
   end

   assign iREN       = (state_q == StFill);
   assign iaddr      = iREN ? fill_addr : '0;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         tag_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         victim_q     <= '0;
         valid_q      <= '0;
         lru_q        <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (iinval) begin
                  valid_q <= '0;
               end else if (ihit) begin
                  lru_q[req.idx] <= lru_hit_upd;
                  hit_count_q    <= hit_count_q + 32'd1;
               end else if (miss) begin
                  tag_q                    <= req.tag;
                  idx_q                    <= req.idx;
                  cnt_q                    <= '0;
                  victim_q                 <= victim;
                  // The victim is being overwritten; an aborted fill must leave it invalid.
                  valid_q[req.idx][victim] <= 1'b0;
                  miss_count_q             <= miss_count_q + 32'd1;
                  state_q                  <= StFill;
               end
            end
            StFill: begin
               if (iinval) begin
                  valid_q <= '0;
                  state_q <= StIdle;
               end else if (!iwait) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (last_beat) begin
                     valid_q[idx_q][victim_q] <= 1'b1;
                     lru_q[idx_q]             <= lru_fill_upd;
                     state_q                  <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (fill_beat) begin
         data_q[idx_q][victim_q][cnt_q] <= iload;
         if (last_beat) begin
            tags_q[idx_q][victim_q] <= tag_q;
         end
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Randomised scoreboard bench for icache_assoc against a timestamp-LRU reference model.
module tb_icache_assoc;

   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;
   localparam int LAT   = 2;

   logic        CLK, RST, imemREN, ihit, iinval, iREN, iwait;
   logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        was_hit;
      logic [31:0] hc;
      logic [31:0] mc;
   } resp_t;

   resp_t       rq[$];
   logic [31:0] fq[$];
   bit          mv   [SETS][WAYS];
   int          mtag [SETS][WAYS];
   int          mts  [SETS][WAYS];
   int          now_t;
   logic [31:0] m_hits, m_misses;
   logic [31:0] last_addr;
   logic        fill_seen;
   int          wcnt;

   icache_assoc #(
      .CPUID(0),
      .SETS (SETS),
      .WAYS (WAYS),
      .WORDS(WORDS)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .imemREN   (imemREN),
      .imemaddr  (imemaddr),
      .ihit      (ihit),
      .imemload  (imemload),
      .iinval    (iinval),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iwait     (iwait),
      .iload     (iload),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a >> 2) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // Memory: each requested word is ready LAT cycles after iREN is first seen.
   always @(posedge CLK or posedge RST) begin
      if (RST) wcnt <= 0;
      else if (!iREN || wcnt == LAT - 1) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end
   assign iwait = !(iREN && wcnt == LAT - 1);
   assign iload = mem_word(iaddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear_valid();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
   endfunction

   function automatic void model_reset();
      model_clear_valid();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mts[s][w] = 0;
      now_t    = 0;
      m_hits   = '0;
      m_misses = '0;
   endfunction

   function automatic void model_access(input logic [31:0] a);
      int  blk, idx, tag, way;
      bit  hit;
      blk = int'(a >> 2) / WORDS;
      idx = blk % SETS;
      tag = blk / SETS;
      hit = 1'b0;
      way = 0;
      for (int w = 0; w < WAYS; w++)
         if (!hit && mv[idx][w] && mtag[idx][w] == tag) begin
            hit = 1'b1;
            way = w;
         end
      if (!hit) begin
         m_misses = m_misses + 1;
         way = WAYS;
         for (int w = WAYS - 1; w >= 0; w--) if (!mv[idx][w]) way = w;
         if (way == WAYS) begin
            way = 0;
            for (int w = 1; w < WAYS; w++) if (mts[idx][w] < mts[idx][way]) way = w;
         end
         for (int k = 0; k < WORDS; k++) fq.push_back(32'((blk * WORDS + k) * 4));
         mv[idx][way]   = 1'b1;
         mtag[idx][way] = tag;
      end
      rq.push_back('{data: mem_word(a), was_hit: hit, hc: m_hits, mc: m_misses});
      m_hits = m_hits + 1;
      now_t++;
      mts[idx][way] = now_t;
   endfunction

   // Monitor: checks every fill beat and every hit against the queued expectations.
   initial begin
      resp_t       r;
      logic [31:0] e;
      fill_seen = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (iREN && !iwait) begin
               if (fq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL fill_unexpected: got iaddr %h expected no fill", iaddr);
               end else begin
                  e = fq.pop_front();
                  chk("fill_addr", iaddr, e);
               end
            end
            if (ihit) begin
               if (rq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL hit_unexpected: got ihit addr %h expected none", imemaddr);
               end else begin
                  r = rq.pop_front();
                  chk("hit_data", imemload, r.data);
                  chk("hit_kind", 32'(!fill_seen), 32'(r.was_hit));
                  chk("hit_count", hit_count, r.hc);
                  chk("miss_count", miss_count, r.mc);
               end
               fill_seen = 1'b0;
            end else if (!imemREN) begin
               fill_seen = 1'b0;
            end else if (iREN) begin
               fill_seen = 1'b1;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_access(input logic [31:0] a);
      int n;
      model_access(a);
      imemREN  = 1'b1;
      imemaddr = a;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!ihit && n < 200);
      if (!ihit) chk("ihit_timeout", 32'(ihit), 32'd1);
      @(posedge CLK);
      #1;
      imemREN   = 1'b0;
      last_addr = a;
   endtask

   task automatic inv_idle();
      imemREN  = 1'b1;
      imemaddr = last_addr;
      iinval   = 1'b1;
      @(negedge CLK);
      chk("inval_ihit", 32'(ihit), 32'd0);
      chk("inval_imemload", imemload, 32'd0);
      @(posedge CLK);
      #1;
      iinval  = 1'b0;
      imemREN = 1'b0;
      model_clear_valid();
      idle(1);
   endtask

   task automatic abort_fill(input logic [31:0] a);
      int n;
      m_misses = m_misses + 1;
      fq.push_back(a);
      imemREN  = 1'b1;
      imemaddr = a;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(iREN && !iwait) && n < 50);
      chk("abort_first_beat", 32'(iREN && !iwait), 32'd1);
      @(posedge CLK);
      #1;
      iinval  = 1'b1;
      imemREN = 1'b0;
      @(negedge CLK);
      chk("abort_iren_hold", 32'(iREN), 32'd1);
      chk("abort_no_hit", 32'(ihit), 32'd0);
      @(posedge CLK);
      #1;
      iinval = 1'b0;
      @(negedge CLK);
      chk("abort_iren_drop", 32'(iREN), 32'd0);
      chk("abort_miss_count", miss_count, m_misses);
      chk("abort_hit_count", hit_count, m_hits);
      model_clear_valid();
      idle(1);
   endtask

   task automatic reset_mid_fill(input logic [31:0] a);
      int n;
      imemREN  = 1'b1;
      imemaddr = a;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!iREN && n < 20);
      chk("rst_fill_started", 32'(iREN), 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("rst_ihit", 32'(ihit), 32'd0);
      chk("rst_iren", 32'(iREN), 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
      imemREN = 1'b0;
      #1 RST = 1'b0;
      model_reset();
      idle(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = '0;
      iinval   = 1'b0;
      last_addr = '0;
      model_reset();
      #12;
      chk("reset_ihit", 32'(ihit), 32'd0);
      chk("reset_imemload", imemload, 32'd0);
      chk("reset_iren", 32'(iREN), 32'd0);
      chk("reset_iaddr", iaddr, 32'd0);
      chk("reset_hit_count", hit_count, 32'd0);
      chk("reset_miss_count", miss_count, 32'd0);
      #1 RST = 1'b0;
      idle(1);

      // Conflicting blocks in set 0 exercise the LRU order.
      do_access(32'h0000_0040);
      do_access(32'h0000_0044);
      do_access(32'h0000_0080);
      do_access(32'h0000_00C0);
      do_access(32'h0000_0040);
      do_access(32'h0000_0080);
      do_access(32'h0000_00C4);

      inv_idle();
      do_access(last_addr);

      abort_fill(32'h0000_0100);
      do_access(32'h0000_0100);
      do_access(32'h0000_0104);

      for (int i = 0; i < 160; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            inv_idle();
         end else begin
            a = 32'((($urandom_range(0, 5) * SETS + $urandom_range(0, 2)) * WORDS
                     + $urandom_range(0, WORDS - 1)) * 4);
            do_access(a);
         end
         idle(int'($urandom_range(0, 2)));
      end

      inv_idle();
      reset_mid_fill(32'h0000_0040);
      do_access(32'h0000_0040);

      force dut.hit_count_q = 32'hFFFF_FFFF;
      @(negedge CLK);
      release dut.hit_count_q;
      m_hits = 32'hFFFF_FFFF;
      chk("forced_hit_count", hit_count, 32'hFFFF_FFFF);
      @(posedge CLK);
      #1;
      do_access(last_addr);
      chk("hit_count_wrap", hit_count, m_hits);
      chk("hit_count_zero", hit_count, 32'd0);

      idle(2);
      chk("resp_queue_drained", 32'(rq.size()), 32'd0);
      chk("fill_queue_drained", 32'(fq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
